// File: rtl/shift_window_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// shift_window_pkg : shared defaults and width helpers for shift_window
// Rev 1.0
// ---------------------------------------------------------------------
package shift_window_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 3;

  // Accumulator width: wide enough for DEPTH full-scale samples.
  function automatic int sum_w(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_window_acc.sv
`default_nettype none
// ---------------------------------------------------------------------
// shift_window_acc : incremental running sum of the shift_window taps
// Rev 1.0
// ---------------------------------------------------------------------
module shift_window_acc
  import shift_window_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             shift_en,
  input  logic [DATA_W-1:0]                din,
  input  logic [DATA_W-1:0]                tap_last,
  output logic [sum_w(DATA_W, DEPTH)-1:0]  sum
);

  localparam int SW = sum_w(DATA_W, DEPTH);

  logic [SW-1:0] r_sum;

  // Modular wrap of the intermediate is harmless: the true result always fits SW bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (shift_en) begin
      r_sum <= r_sum + SW'(din) - SW'(tap_last);
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/shift_window.sv
`default_nettype none
// ---------------------------------------------------------------------
// shift_window : DEPTH-tap sliding sample window with fill tracking;
// optional running sum when SHIFT_WINDOW_SUM_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------
module shift_window
  import shift_window_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            shift_en,
  input  logic                            clear,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W*DEPTH-1:0]         taps,
  output logic [fill_w(DEPTH)-1:0]        fill_count,
  output logic                            window_full,
  output logic                            win_strobe
`ifdef SHIFT_WINDOW_SUM_EN
  ,
  output logic [sum_w(DATA_W, DEPTH)-1:0] sum_out
`endif
);

  localparam int               CNT_W       = fill_w(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] r_count;
  logic             r_strobe;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] r_q;

    if (gi == 0) begin : g_head
      assign w_src = din;
    end else begin : g_body
      assign w_src = g_tap[gi-1].r_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (clear) begin
        r_q <= '0;
      end else if (shift_en) begin
        r_q <= w_src;
      end
    end

    assign taps[gi*DATA_W +: DATA_W] = r_q;
  end

  // Strobe fires when the accepted shift lands the count on DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else if (clear) begin
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else if (shift_en) begin
      if (r_count != c_DEPTH_CNT) begin
        r_count <= r_count + CNT_W'(1);
      end
      r_strobe <= (r_count >= (c_DEPTH_CNT - CNT_W'(1)));
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign fill_count  = r_count;
  assign window_full = (r_count == c_DEPTH_CNT);
  assign win_strobe  = r_strobe;

`ifdef SHIFT_WINDOW_SUM_EN
  shift_window_acc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_acc (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .shift_en (shift_en),
    .din      (din),
    .tap_last (g_tap[DEPTH-1].r_q),
    .sum      (sum_out)
  );
`endif

endmodule
`default_nettype wire
